// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: single-outstanding imem requests feeding a DEPTH-entry decode queue.
// Defining IFQ_PERF_CNT_EN adds the perf_fetch_cnt / perf_kill_cnt / perf_full_cnt outputs.
module if_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        dec_valid,
   output logic [31:0] dec_inst,
   output logic [31:0] dec_pc,
   input  logic        dec_ready
`ifdef IFQ_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_kill_cnt,
   output logic [31:0] perf_full_cnt
`endif
);

   localparam int            PW      = $clog2(DEPTH);
   localparam int            CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_KILL = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   inst_mem_q [DEPTH];
   logic [31:0]   inst_mem_d [DEPTH];
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   pc_mem_d   [DEPTH];
   logic          issue_s, enq_s, pop_s, drop_s, dec_valid_s;
`ifdef IFQ_PERF_CNT_EN
   logic [31:0]   perf_fetch_q, perf_fetch_d;
   logic [31:0]   perf_kill_q, perf_kill_d;
   logic [31:0]   perf_full_q, perf_full_d;
`endif

   // Handshake qualifiers; flush overrides issue, enqueue and pop, and reset blocks issue.
   always_comb begin
      dec_valid_s = (count_q != {CW{1'b0}});
      issue_s     = rst && (state_q == ST_RUN) && (count_q < DEPTH_C) && !flush;
      enq_s       = (state_q == ST_WAIT) && imem_rvalid && !flush;
      pop_s       = dec_valid_s && dec_ready && !flush;
      drop_s      = imem_rvalid && !enq_s;
   end

   assign imem_req  = issue_s;
   assign imem_addr = fetch_pc_q;
   assign dec_valid = dec_valid_s;
   assign dec_inst  = dec_valid_s ? inst_mem_q[rd_ptr_q] : 32'h0000_0000;
   assign dec_pc    = dec_valid_s ? pc_mem_q[rd_ptr_q]   : 32'h0000_0000;

   // Next-state logic for the request FSM, fetch PC and queue bookkeeping.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      inst_mem_d = inst_mem_q;
      pc_mem_d   = pc_mem_q;
      case (state_q)
         ST_RUN: begin
            if (issue_s) state_d = ST_WAIT;
            else         state_d = ST_RUN;
         end
         ST_WAIT: begin
            if (imem_rvalid) state_d = ST_RUN;
            else if (flush)  state_d = ST_KILL;
            else             state_d = ST_WAIT;
         end
         ST_KILL: begin
            if (imem_rvalid) state_d = ST_RUN;
            else             state_d = ST_KILL;
         end
         default: state_d = ST_RUN;
      endcase
      if (flush) begin
         count_d    = {CW{1'b0}};
         rd_ptr_d   = {PW{1'b0}};
         wr_ptr_d   = {PW{1'b0}};
         fetch_pc_d = flush_pc & 32'hFFFF_FFFC;
      end else begin
         if (issue_s) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            req_pc_d   = fetch_pc_q;
         end else begin
            fetch_pc_d = fetch_pc_q;
            req_pc_d   = req_pc_q;
         end
         if (enq_s) begin
            inst_mem_d[wr_ptr_q] = imem_rdata;
            pc_mem_d[wr_ptr_q]   = req_pc_q;
            wr_ptr_d             = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) rd_ptr_d = rd_ptr_q + PTR_ONE;
         else       rd_ptr_d = rd_ptr_q;
         case ({enq_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

`ifdef IFQ_PERF_CNT_EN
   // Free-running event counters; deliberately untouched by flush.
   always_comb begin
      perf_fetch_d = perf_fetch_q + {31'd0, issue_s};
      perf_kill_d  = perf_kill_q + {31'd0, drop_s};
      perf_full_d  = perf_full_q + {31'd0, (count_q == DEPTH_C)};
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_kill_cnt  = perf_kill_q;
   assign perf_full_cnt  = perf_full_q;
`endif

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= 32'h0000_0000;
         count_q    <= {CW{1'b0}};
         rd_ptr_q   <= {PW{1'b0}};
         wr_ptr_q   <= {PW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            inst_mem_q[i] <= 32'h0000_0000;
            pc_mem_q[i]   <= 32'h0000_0000;
         end
`ifdef IFQ_PERF_CNT_EN
         perf_fetch_q <= 32'h0000_0000;
         perf_kill_q  <= 32'h0000_0000;
         perf_full_q  <= 32'h0000_0000;
`endif
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         inst_mem_q <= inst_mem_d;
         pc_mem_q   <= pc_mem_d;
`ifdef IFQ_PERF_CNT_EN
         perf_fetch_q <= perf_fetch_d;
         perf_kill_q  <= perf_kill_d;
         perf_full_q  <= perf_full_d;
`endif
      end
   end

   // drop_s only feeds the optional kill counter.
   logic unused_s;
   assign unused_s = drop_s;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Scoreboard bench for if_prefetch_queue: a latency-programmable memory model plus
// queues of expected decode entries and the expected next fetch address.
module tb_if_prefetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata  = 32'h0;
   logic        flush       = 1'b0;
   logic [31:0] flush_pc    = 32'h0;
   logic        dec_valid;
   logic [31:0] dec_inst;
   logic [31:0] dec_pc;
   logic        dec_ready   = 1'b0;
`ifdef IFQ_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_kill_cnt, perf_full_cnt;
`endif

   if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .flush(flush), .flush_pc(flush_pc),
      .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
      .dec_ready(dec_ready)
`ifdef IFQ_PERF_CNT_EN
      , .perf_fetch_cnt(perf_fetch_cnt), .perf_kill_cnt(perf_kill_cnt),
      .perf_full_cnt(perf_full_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Scoreboard and memory-model state.
   logic [31:0] exp_pc_q [$];
   logic [31:0] exp_inst_q [$];
   logic [31:0] exp_fetch_pc;
   bit          pending, killed, use_override, ready_rand, ready_fixed;
   int          cnt, mem_lat;
   logic [31:0] pend_addr, data_override;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          fetch_model, kill_model, full_model;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return {addr[15:0] ^ 16'hC3A5, addr[15:0]};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_pc_q.delete();
      exp_inst_q.delete();
      exp_fetch_pc = RESET_PC;
      pending      = 1'b0;
      killed       = 1'b0;
      use_override = 1'b0;
      fetch_model  = 0;
      kill_model   = 0;
      full_model   = 0;
   endtask

   // One clock cycle: drive inputs, check outputs, advance the model.
   task automatic cycle(input bit do_flush, input logic [31:0] fpc, input bit stray);
      bit          responding, push, exp_req;
      logic [31:0] rword;
      int          sz;
      responding  = 1'b0;
      push        = 1'b0;
      rword       = 32'h0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (pending) begin
         if (cnt == 0) begin
            responding   = 1'b1;
            rword        = use_override ? data_override : mem_word(pend_addr);
            use_override = 1'b0;
            imem_rvalid  = 1'b1;
            imem_rdata   = rword;
            push         = !killed && !do_flush && rst;
         end else begin
            cnt--;
         end
      end else if (stray) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hBAD0_BAD0;
      end
      flush     = do_flush;
      flush_pc  = fpc;
      dec_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
      #1;
      sz      = exp_pc_q.size();
      exp_req = rst && !pending && (sz < DEPTH) && !do_flush;
      check_eq("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      if (imem_req && exp_req) check_eq("imem_addr", imem_addr, exp_fetch_pc);
      check_eq("dec_valid", {31'd0, dec_valid}, {31'd0, (sz != 0)});
      if (sz != 0) begin
         check_eq("dec_pc", dec_pc, exp_pc_q[0]);
         check_eq("dec_inst", dec_inst, exp_inst_q[0]);
      end else begin
         check_eq("dec_pc_empty", dec_pc, 32'h0);
         check_eq("dec_inst_empty", dec_inst, 32'h0);
      end
      if (rst && sz == DEPTH) full_model++;
      if (rst && ((responding && !push) || (stray && !pending))) kill_model++;
      if ((sz != 0) && dec_ready && !do_flush && rst) begin
         void'(exp_pc_q.pop_front());
         void'(exp_inst_q.pop_front());
      end
      if (do_flush && pending && !responding) killed = 1'b1;
      if (responding) pending = 1'b0;
      if (push) begin
         exp_pc_q.push_back(pend_addr);
         exp_inst_q.push_back(rword);
      end
      if (imem_req) begin
         if (rst) fetch_model++;
         pending      = 1'b1;
         killed       = 1'b0;
         pend_addr    = imem_addr;
         cnt          = mem_lat - 1;
         exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
      if (do_flush) begin
         exp_pc_q.delete();
         exp_inst_q.delete();
         exp_fetch_pc = fpc & 32'hFFFF_FFFC;
      end
      if (!rst) model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0);
   endtask

   // Advance until a request is in flight with the given remaining latency.
   task automatic wait_pending(input int due);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (pending && cnt == due) found = 1'b1;
         else cycle(1'b0, 32'h0, 1'b0);
      end
      check_eq("wait_timeout", {31'd0, found}, 32'd1);
   endtask

   initial begin
      int kill_base;
      mem_lat     = 1;
      ready_rand  = 1'b0;
      ready_fixed = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      cycle(1'b0, 32'h0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0);
      rst = 1'b1;

      // Latency 1, decode always ready: sequential fetch every two cycles.
      run(20);
      // Decode stalled: queue fills to DEPTH, then drains and issue resumes.
      ready_fixed = 1'b0;
      run(20);
      ready_fixed = 1'b1;
      run(12);

      // Flush while waiting; stale 0xDEADBEEF response arrives two cycles later.
      mem_lat = 3;
      wait_pending(2);
      kill_base     = kill_model;
      use_override  = 1'b1;
      data_override = 32'hDEAD_BEEF;
      cycle(1'b1, 32'h0000_0100, 1'b0);
      run(10);
`ifdef IFQ_PERF_CNT_EN
      check_eq("perf_kill_delta", perf_kill_cnt - 32'(kill_base), 32'd1);
`endif

      // Flush coincident with the response.
      mem_lat = 2;
      wait_pending(0);
      cycle(1'b1, 32'h0000_0200, 1'b0);
      run(6);

      // Misaligned target and address wrap.
      cycle(1'b1, 32'h0000_0203, 1'b0);
      run(6);
      cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
      run(8);

      // Reset while a request is in flight, then a stray response in RUN.
      mem_lat = 3;
      wait_pending(2);
      rst = 1'b0;
      cycle(1'b0, 32'h0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0);
      rst = 1'b1;
      cycle(1'b0, 32'h0, 1'b1);
      run(10);

      // Random latency, decode back-pressure and flushes.
      ready_rand = 1'b1;
      for (int i = 0; i < 400; i++) begin
         mem_lat = $urandom_range(1, 3);
         cycle(($urandom_range(0, 15) == 0), $urandom, 1'b0);
      end

`ifdef IFQ_PERF_CNT_EN
      check_eq("perf_fetch", perf_fetch_cnt, 32'(fetch_model));
      check_eq("perf_kill", perf_kill_cnt, 32'(kill_model));
      check_eq("perf_full", perf_full_cnt, 32'(full_model));
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
